// File: rtl/rv32i_types.sv
// Shared RV32I types: RVFI retirement record and commit-monitor enums/constants.
package rv32i_types;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ORDER_W  = 64;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned MASK_W   = 4;

    // One retired instruction as driven by the pipeline (313 bits)
    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic              trap;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic              load_regfile;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [MASK_W-1:0] mem_rmask;
        logic [MASK_W-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_signals;

    typedef enum logic [3:0] {
        ERR_NONE      = 4'd0,
        ERR_TRAP      = 4'd1,
        ERR_PC_ALIGN  = 4'd2,
        ERR_PC_SEQ    = 4'd3,
        ERR_X0_WRITE  = 4'd4,
        ERR_RS1       = 4'd5,
        ERR_RS2       = 4'd6,
        ERR_MASK      = 4'd7,
        ERR_MEM_ALIGN = 4'd8,
        ERR_POST_HALT = 4'd9
    } rvfi_mon_err_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } rvfi_mon_state_t;

    // Byte, halfword and word lane patterns a memory access may use
    localparam logic [MASK_W-1:0] MASK_B0 = 4'b0001;
    localparam logic [MASK_W-1:0] MASK_B1 = 4'b0010;
    localparam logic [MASK_W-1:0] MASK_B2 = 4'b0100;
    localparam logic [MASK_W-1:0] MASK_B3 = 4'b1000;
    localparam logic [MASK_W-1:0] MASK_HL = 4'b0011;
    localparam logic [MASK_W-1:0] MASK_HH = 4'b1100;
    localparam logic [MASK_W-1:0] MASK_W4 = 4'b1111;

    function automatic logic mask_legal(input logic [MASK_W-1:0] m);
        return (m == MASK_B0) || (m == MASK_B1) || (m == MASK_B2) || (m == MASK_B3) ||
               (m == MASK_HL) || (m == MASK_HH) || (m == MASK_W4);
    endfunction

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow architectural register file: 32x32, two combinational reads, one
// synchronous write, x0 hardwired to zero, synchronous clear.
// Storage exists only when RVFI_MON_SHADOW_EN is defined; otherwise reads are zero.
module rvfi_shadow_regfile
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_c_o,
    output logic [XLEN-1:0]   rdata2_c_o
);

`ifdef RVFI_MON_SHADOW_EN
    logic [XLEN-1:0] regs_q [NUM_REGS];

    // Register write; x0 is never written so it keeps its cleared value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_c_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_c_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`else
    logic unused_c;

    assign rdata1_c_o = '0;
    assign rdata2_c_o = '0;
    assign unused_c   = ^{clk, rst, we_i, waddr_i, wdata_i, raddr1_i, raddr2_i};
`endif

endmodule

// File: rtl/rvfi_commit_monitor.sv
// RVFI commit monitor: numbers each retirement, checks it for architectural
// consistency, records the first violation stickily and detects branch-to-self.
// Optional shadow-register operand checks: define RVFI_MON_SHADOW_EN.
module rvfi_commit_monitor
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0060,
    parameter bit          CHECK_FIRST_PC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit,
    input  rvfi_signals          rvfi,
    output logic [ORDER_W-1:0]   order,
    output logic                 error,
    output rvfi_mon_err_t        err_code,
    output logic [ORDER_W-1:0]   err_order,
    output logic [XLEN-1:0]      err_pc,
    output logic                 halt
);

    rvfi_mon_state_t      state_q, state_d;
    logic [ORDER_W-1:0]   order_q, order_d;
    logic                 error_q, error_d;
    rvfi_mon_err_t        err_code_q, err_code_d;
    logic [ORDER_W-1:0]   err_order_q, err_order_d;
    logic [XLEN-1:0]      err_pc_q, err_pc_d;
    logic                 halt_q, halt_d;
    logic [XLEN-1:0]      exp_pc_q, exp_pc_d;
    logic                 first_q, first_d;

    logic [XLEN-1:0]      rs1_shadow_c, rs2_shadow_c;
    logic                 rs1_bad_c, rs2_bad_c;
    logic                 mask_bad_c, mem_misalign_c, halt_idiom_c;
    rvfi_mon_err_t        code_c;
    logic                 unused_c;

    rvfi_shadow_regfile u_shadow (
        .clk        (clk),
        .rst        (rst),
        .we_i       (commit && rvfi.load_regfile),
        .waddr_i    (rvfi.rd_addr),
        .wdata_i    (rvfi.rd_wdata),
        .raddr1_i   (rvfi.rs1_addr),
        .raddr2_i   (rvfi.rs2_addr),
        .rdata1_c_o (rs1_shadow_c),
        .rdata2_c_o (rs2_shadow_c)
    );

`ifdef RVFI_MON_SHADOW_EN
    assign rs1_bad_c = (rvfi.rs1_rdata != rs1_shadow_c);
    assign rs2_bad_c = (rvfi.rs2_rdata != rs2_shadow_c);
    assign unused_c  = ^{rvfi.inst, rvfi.mem_addr[XLEN-1:2], rvfi.mem_rdata, rvfi.mem_wdata};
`else
    assign rs1_bad_c = 1'b0;
    assign rs2_bad_c = 1'b0;
    assign unused_c  = ^{rvfi.inst, rvfi.mem_addr[XLEN-1:2], rvfi.mem_rdata, rvfi.mem_wdata,
                         rvfi.rs1_addr, rvfi.rs2_addr, rvfi.rs1_rdata, rvfi.rs2_rdata,
                         rs1_shadow_c, rs2_shadow_c};
`endif

    assign mask_bad_c = ((rvfi.mem_rmask != '0) && (rvfi.mem_wmask != '0)) ||
                        ((rvfi.mem_rmask != '0) && !mask_legal(rvfi.mem_rmask)) ||
                        ((rvfi.mem_wmask != '0) && !mask_legal(rvfi.mem_wmask));
    assign mem_misalign_c = ((rvfi.mem_rmask | rvfi.mem_wmask) != '0) &&
                            (rvfi.mem_addr[1:0] != 2'b00);
    assign halt_idiom_c   = (rvfi.pc_wdata == rvfi.pc_rdata) && !rvfi.trap;

    // Priority-encoded violation code for the current record (lowest code wins)
    always_comb begin
        code_c = ERR_NONE;
        if (rvfi.trap) begin
            code_c = ERR_TRAP;
        end else if ((rvfi.pc_rdata[1:0] != 2'b00) || (rvfi.pc_wdata[1:0] != 2'b00)) begin
            code_c = ERR_PC_ALIGN;
        end else if ((!first_q || CHECK_FIRST_PC) && (rvfi.pc_rdata != exp_pc_q)) begin
            code_c = ERR_PC_SEQ;
        end else if (rvfi.load_regfile && (rvfi.rd_addr == '0) && (rvfi.rd_wdata != '0)) begin
            code_c = ERR_X0_WRITE;
        end else if (rs1_bad_c) begin
            code_c = ERR_RS1;
        end else if (rs2_bad_c) begin
            code_c = ERR_RS2;
        end else if (mask_bad_c) begin
            code_c = ERR_MASK;
        end else if (mem_misalign_c) begin
            code_c = ERR_MEM_ALIGN;
        end else if (state_q == HALTED) begin
            code_c = ERR_POST_HALT;
        end
    end

    // Next-state: order/PC tracking on every commit, first-violation capture, halt FSM
    always_comb begin
        state_d     = state_q;
        order_d     = order_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_order_d = err_order_q;
        err_pc_d    = err_pc_q;
        halt_d      = halt_q;
        exp_pc_d    = exp_pc_q;
        first_d     = first_q;
        if (commit) begin
            order_d  = order_q + ORDER_W'(1);
            exp_pc_d = rvfi.pc_wdata;
            first_d  = 1'b0;
            if ((state_q != FAULT) && (code_c != ERR_NONE)) begin
                state_d     = FAULT;
                error_d     = 1'b1;
                err_code_d  = code_c;
                err_order_d = order_q;
                err_pc_d    = rvfi.pc_rdata;
            end
            if ((state_q == RUN) && halt_idiom_c) begin
                halt_d = 1'b1;
                if (code_c == ERR_NONE) begin
                    state_d = HALTED;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            order_q     <= '0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_order_q <= '0;
            err_pc_q    <= '0;
            halt_q      <= 1'b0;
            exp_pc_q    <= RESET_PC;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            order_q     <= order_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_order_q <= err_order_d;
            err_pc_q    <= err_pc_d;
            halt_q      <= halt_d;
            exp_pc_q    <= exp_pc_d;
            first_q     <= first_d;
        end
    end

    assign order     = order_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign err_order = err_order_q;
    assign err_pc    = err_pc_q;
    assign halt      = halt_q;

endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// Scoreboard bench for rvfi_commit_monitor: directed scenarios plus randomized
// episodes, each expectation computed by a rule-level reference model.
module tb_rvfi_commit_monitor;
    import rv32i_types::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          commit;
    rvfi_signals   rvfi;
    logic [63:0]   order;
    logic          error;
    rvfi_mon_err_t err_code;
    logic [63:0]   err_order;
    logic [31:0]   err_pc;
    logic          halt;

    always #5 clk = ~clk;

    rvfi_commit_monitor #(
        .RESET_PC       (32'h0000_0060),
        .CHECK_FIRST_PC (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .commit    (commit),
        .rvfi      (rvfi),
        .order     (order),
        .error     (error),
        .err_code  (err_code),
        .err_order (err_order),
        .err_pc    (err_pc),
        .halt      (halt)
    );

    // ---------------- reference model ----------------
    localparam logic [31:0] M_RESET_PC = 32'h60;
    logic [63:0] m_order, m_eorder;
    logic        m_error, m_halt;
    logic [3:0]  m_code;
    logic [31:0] m_epc, m_exp_pc;
    bit          m_first, m_halted, m_faulted;
    logic [31:0] m_regs [32];
    logic [3:0]  legal [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    function automatic bit in_legal(input logic [3:0] m);
        for (int i = 0; i < 7; i++) if (legal[i] == m) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_order = 0; m_error = 0; m_code = 0; m_eorder = 0; m_epc = 0; m_halt = 0;
        m_exp_pc = M_RESET_PC; m_first = 1; m_halted = 0; m_faulted = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
    endtask

    task automatic model_commit(input rvfi_signals r);
        int hits[$];
        int code;
        bit idle_run;
        if (r.trap) hits.push_back(1);
        if (r.pc_rdata % 4 != 0 || r.pc_wdata % 4 != 0) hits.push_back(2);
        if (r.pc_rdata != m_exp_pc) hits.push_back(3);
        if (r.load_regfile && r.rd_addr == 0 && r.rd_wdata != 0) hits.push_back(4);
`ifdef RVFI_MON_SHADOW_EN
        if (r.rs1_rdata != m_regs[r.rs1_addr]) hits.push_back(5);
        if (r.rs2_rdata != m_regs[r.rs2_addr]) hits.push_back(6);
`endif
        if ((r.mem_rmask != 0 && r.mem_wmask != 0) ||
            (r.mem_rmask != 0 && !in_legal(r.mem_rmask)) ||
            (r.mem_wmask != 0 && !in_legal(r.mem_wmask))) hits.push_back(7);
        if ((r.mem_rmask != 0 || r.mem_wmask != 0) && r.mem_addr % 4 != 0) hits.push_back(8);
        if (m_halted) hits.push_back(9);
        code = 0;
        foreach (hits[i]) if (code == 0 || hits[i] < code) code = hits[i];
        idle_run = !m_halted && !m_faulted;
        if (!m_faulted && code != 0) begin
            m_faulted = 1; m_error = 1; m_code = 4'(code); m_eorder = m_order; m_epc = r.pc_rdata;
        end
        if (idle_run && r.pc_wdata == r.pc_rdata && !r.trap) begin
            m_halt = 1;
            m_halted = 1;
        end
        if (r.load_regfile && r.rd_addr != 0) m_regs[r.rd_addr] = r.rd_wdata;
        m_exp_pc = r.pc_wdata;
        m_first  = 0;
        m_order  = m_order + 1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] order;
        logic        error;
        logic [3:0]  code;
        logic [63:0] eorder;
        logic [31:0] epc;
        logic        halt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic c, input rvfi_signals r);
        exp_t e;
        @(negedge clk);
        rst = rs; commit = c; rvfi = r;
        if (rs) model_reset();
        else if (c) model_commit(r);
        e.order = m_order; e.error = m_error; e.code = m_code;
        e.eorder = m_eorder; e.epc = m_epc; e.halt = m_halt;
        sb_q.push_back(e);
    endtask

    // Monitor: every edge after a driven cycle, compare outputs with the queued expectation
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("order",     order,          e.order);
            chk("error",     64'(error),     64'(e.error));
            chk("err_code",  64'(err_code),  64'(e.code));
            chk("err_order", err_order,      e.eorder);
            chk("err_pc",    64'(err_pc),    64'(e.epc));
            chk("halt",      64'(halt),      64'(e.halt));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic rvfi_signals mk(input logic [31:0] pr, input logic [31:0] pw);
        rvfi_signals r;
        r = '0;
        r.pc_rdata = pr;
        r.pc_wdata = pw;
        return r;
    endfunction

    function automatic rvfi_signals junk();
        logic [319:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return rvfi_signals'(v[312:0]);
    endfunction

    function automatic rvfi_signals gen();
        rvfi_signals r;
        int k;
        r = junk();
        r.trap = ($urandom_range(0, 39) == 0);
        k = $urandom_range(0, 31);
        if (k == 0)      r.pc_rdata = $urandom() & 32'hFFFF_FFFC;
        else if (k == 1) r.pc_rdata = m_exp_pc | 32'($urandom_range(1, 3));
        else             r.pc_rdata = m_exp_pc;
        k = $urandom_range(0, 15);
        if (k == 0)      r.pc_wdata = r.pc_rdata;
        else if (k == 1) r.pc_wdata = $urandom();
        else if (k <= 3) r.pc_wdata = $urandom() & 32'hFFFF_FFFC;
        else             r.pc_wdata = r.pc_rdata + 32'd4;
        if ($urandom_range(0, 15) != 0) r.rs1_rdata = m_regs[r.rs1_addr];
        if ($urandom_range(0, 15) != 0) r.rs2_rdata = m_regs[r.rs2_addr];
        if (r.rd_addr == 0 && $urandom_range(0, 3) != 0) r.rd_wdata = 0;
        k = $urandom_range(0, 7);
        r.mem_rmask = 0; r.mem_wmask = 0;
        if (k == 4)      r.mem_rmask = legal[$urandom_range(0, 6)];
        else if (k == 5) r.mem_wmask = legal[$urandom_range(0, 6)];
        else if (k == 6) r.mem_rmask = 4'($urandom());
        else if (k == 7) begin
            r.mem_rmask = legal[$urandom_range(0, 6)];
            r.mem_wmask = legal[$urandom_range(0, 6)];
        end
        if ($urandom_range(0, 5) != 0) r.mem_addr[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rvfi_signals r;
        rst = 1'b1; commit = 1'b0; rvfi = '0;
        model_reset();

        // Basic flow with shadow hit
        drive(1, 0, '0);
        r = mk(32'h60, 32'h64); r.load_regfile = 1; r.rd_addr = 1; r.rd_wdata = 5;
        drive(0, 1, r);
        r = mk(32'h64, 32'h68); r.rs1_addr = 1; r.rs1_rdata = 5;
        drive(0, 1, r);
        drive(0, 0, junk());

        // PC sequence break
        drive(1, 0, '0);
        drive(0, 1, mk(32'h60, 32'h64));
        drive(0, 1, mk(32'h68, 32'h6C));
        drive(0, 1, mk(32'h6C, 32'h70));

        // x0 write, illegal then legal
        drive(1, 0, '0);
        r = mk(32'h60, 32'h64); r.load_regfile = 1; r.rd_addr = 0; r.rd_wdata = 32'h1234;
        drive(0, 1, r);
        drive(1, 0, '0);
        r.rd_wdata = 0;
        drive(0, 1, r);

        // Shadow mismatch on rs2, plus same-register read-before-write
        drive(1, 0, '0);
        r = mk(32'h60, 32'h64); r.load_regfile = 1; r.rd_addr = 2; r.rd_wdata = 32'hDEADBEEF;
        drive(0, 1, r);
        r = mk(32'h64, 32'h68); r.rs2_addr = 2; r.rs2_rdata = 0;
        drive(0, 1, r);
        drive(1, 0, '0);
        r = mk(32'h60, 32'h64); r.load_regfile = 1; r.rd_addr = 3; r.rd_wdata = 7;
        drive(0, 1, r);
        r = mk(32'h64, 32'h68); r.rs1_addr = 3; r.rs1_rdata = 7;
        r.load_regfile = 1; r.rd_addr = 3; r.rd_wdata = 9;
        drive(0, 1, r);

        // Mask checks
        drive(1, 0, '0);
        r = mk(32'h60, 32'h64); r.mem_wmask = 4'b0110;
        drive(0, 1, r);
        drive(1, 0, '0);
        r = mk(32'h60, 32'h64); r.mem_rmask = 4'b1111; r.mem_addr = 32'h102;
        drive(0, 1, r);
        drive(1, 0, '0);
        r = mk(32'h70, 32'h74); r.mem_wmask = 4'b0110;
        drive(0, 1, r);

        // Halt, post-halt commit, then reset (commit in reset cycle ignored)
        drive(1, 0, '0);
        drive(0, 1, mk(32'h60, 32'h80));
        drive(0, 1, mk(32'h80, 32'h80));
        drive(0, 0, junk());
        drive(0, 1, mk(32'h80, 32'h84));
        drive(1, 1, mk(32'h84, 32'h84));
        drive(0, 1, mk(32'h60, 32'h64));
        drive(0, 1, mk(32'h64, 32'h64));

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            drive(1, 1'($urandom()), junk());
            for (int n = 0; n < int'($urandom_range(10, 60)); n++) begin
                if ($urandom_range(0, 59) == 0)     drive(1, 1'($urandom()), junk());
                else if ($urandom_range(0, 7) == 0) drive(0, 0, junk());
                else                                drive(0, 1, gen());
            end
        end

        drive(0, 0, '0);
        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
